// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains an 8-bit synchronous FIFO and serialises each byte as
// start, 8 data bits LSB first, optional even parity, and 1 or 2 stop bits.
// The FIFO has a one-cycle registered read latency, which the LOAD state absorbs.
module fifo_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_data,
   output logic       fifo_rd_en,
   output logic       tx,
   output logic       busy,
   output logic       tx_done
);

   typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP} state_t;

   localparam int              BW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);

   state_t        state, state_n;
   logic [BW-1:0] baud;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift, shift_n;
   logic          par, par_n;
   logic          tx_n;
   logic          baud_end;

   assign baud_end = (baud == BAUD_LAST);

   // Decoded from registered state and counters only, so these never glitch.
   assign busy    = (state != IDLE);
   assign tx_done = (state == STOP) && baud_end && (bit_cnt == STOP_LAST);

   // Next-state, pop request and next line value. The line value is computed
   // from the next state so that tx can be registered without a cycle of lag.
   always_comb begin
      state_n    = state;
      shift_n    = shift;
      par_n      = par;
      fifo_rd_en = 1'b0;
      case (state)
         IDLE: begin
            // Reset gating keeps the pop request low during every reset cycle.
            if (enable && !fifo_empty && !rst) begin
               fifo_rd_en = 1'b1;
               state_n    = LOAD;
            end
         end
         LOAD: begin
            shift_n = fifo_data;
            par_n   = ^fifo_data;
            state_n = START;
         end
         START: begin
            if (baud_end) state_n = DATA;
         end
         DATA: begin
            if (baud_end) begin
               shift_n = {1'b0, shift[7:1]};
               if (bit_cnt == 3'd7) state_n = (PARITY_EN != 0) ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (baud_end) state_n = STOP;
         end
         STOP: begin
            // bit_cnt is reused here to count stop bits.
            if (baud_end && (bit_cnt == STOP_LAST)) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      case (state_n)
         START:   tx_n = 1'b0;
         DATA:    tx_n = shift_n[0];
         PARITY:  tx_n = par_n;
         default: tx_n = 1'b1;
      endcase
   end

   // State, baud/bit counters, shift register and registered serial line.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         baud    <= '0;
         bit_cnt <= '0;
         shift   <= '0;
         par     <= 1'b0;
         tx      <= 1'b1;
      end else begin
         state <= state_n;
         shift <= shift_n;
         par   <= par_n;
         tx    <= tx_n;
         if (state_n != state || baud_end) baud <= '0;
         else                              baud <= baud + 1'b1;
         if (state_n != state) bit_cnt <= '0;
         else if (baud_end)    bit_cnt <= bit_cnt + 3'd1;
      end
   end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmit drain for the 8-bit synchronous FIFO. Pops one byte at a time through the FIFO's read port, absorbing its one-cycle registered read latency, and shifts each byte out as an asynchronous serial frame: start bit, 8 data bits LSB first, optional even parity, 1 or 2 stop bits. Sits directly downstream of the FIFO and is the only master of its `read_en`.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; legal range 2..65535.
- `PARITY_EN`, 0: 1 inserts an even-parity bit after the data bits.
- `STOP_BITS`, 1: number of stop bits; legal values 1 or 2.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `enable`  in  1  permits starting a new frame; sampled only in IDLE.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_data`  in  8  FIFO `data_out`; valid the cycle after a read.
- `fifo_rd_en`  out  1  FIFO `read_en`; single-cycle pop request.
- `tx`  out  1  serial line; idle high.
- `busy`  out  1  high whenever the state is not IDLE.
- `tx_done`  out  1  one-cycle pulse at end of frame.

## Operation
- Reset values: state IDLE, `tx`=1, `busy`=0, `tx_done`=0, `fifo_rd_en`=0, all counters 0, shift register 0.
- States: IDLE, LOAD, START, DATA, PARITY, STOP.
- IDLE: `fifo_rd_en = enable && !fifo_empty && !rst` (combinational from state, gated by reset).
  - Condition true: next state LOAD.
  - Otherwise remain in IDLE.
- LOAD (1 cycle): `fifo_data` is valid.
  - Capture it into the 8-bit shift register.
  - Compute parity as the XOR of all 8 bits.
  - Next state START.
- START: `tx`=0 for `CLKS_PER_BIT` cycles, then DATA.
- DATA: `tx` = shift[0]. Every `CLKS_PER_BIT` cycles, shift right and increment a 3-bit bit counter.
  - After bit 7: go to PARITY if `PARITY_EN`, else STOP.
- PARITY: `tx` = XOR of the data bits (even parity), held for `CLKS_PER_BIT` cycles, then STOP.
- STOP: `tx`=1 for `STOP_BITS*CLKS_PER_BIT` cycles.
  - `tx_done`=1 in the final cycle of STOP only.
  - Then return to IDLE.
- `tx` is registered. `busy` and `tx_done` are decoded from registered state and counters, so neither glitches.
- Baud counter: counts 0..`CLKS_PER_BIT`-1 and wraps to 0. It is cleared on every state change. Width is `$clog2(CLKS_PER_BIT)` with a minimum of 1.
- `enable` deasserted mid-frame: the current frame completes normally; no new pop occurs.
- `fifo_empty` is sampled only in IDLE. Never pop when empty, which also guarantees no underflow of the FIFO counter.
- Synchronous `rst` at any state:
  - On the next edge, state goes to IDLE and `tx`=1.
  - A partially sent byte is discarded and is not re-read.
  - `fifo_rd_en` is 0 during every cycle `rst` is high.

## Timing
- Pop latency: `fifo_rd_en` high in cycle N; LOAD in N+1; `tx` falls at the edge ending N+1. The start bit occupies cycles N+2 .. N+1+`CLKS_PER_BIT`.
- Frame length from START entry to IDLE re-entry: `(1+8+PARITY_EN+STOP_BITS)*CLKS_PER_BIT` cycles.
- Back-to-back bytes:
  - `fifo_rd_en` for the next byte asserts in the first IDLE cycle after `tx_done`.
  - The line stays high for exactly 2 extra cycles (IDLE + LOAD) between frames.
- `fifo_rd_en` is never high for two consecutive cycles. Maximum one pop per frame.

## Test plan
- Single byte, `CLKS_PER_BIT`=4, PARITY_EN=0, STOP_BITS=1. Write 0xA5, then hold `enable`=1.
  - One `fifo_rd_en` pulse; `tx` falls 2 cycles later.
  - `tx` sequence is 0, then 1,0,1,0,0,1,0,1, then 1, each bit 4 cycles.
  - `tx_done` pulses in cycle 40 after START entry; `busy` is high for 41 cycles, including LOAD.
- Back-to-back: preload 0x00, 0xFF, 0x3C.
  - Exactly 3 `fifo_rd_en` pulses; frames decode in order.
  - Inter-frame idle-high is stop time + 2 cycles.
  - FIFO ends empty; no pop while `fifo_empty`=1.
- Parity and stop bits: PARITY_EN=1, STOP_BITS=2.
  - Byte 0x07 gives parity bit 1; byte 0x03 gives parity bit 0.
  - Stop phase is 2*`CLKS_PER_BIT` high; frame is 12 bit-times.
- Empty and disabled:
  - `enable`=1 with the FIFO empty: `fifo_rd_en`, `busy` and `tx_done` stay 0 and `tx`=1.
  - `enable`=0 with 3 bytes queued: no pops.
  - Raising `enable` triggers a pop on the same cycle.
- Reset mid-frame: assert `rst` for 1 cycle during DATA bit 3 of 0x5A.
  - `tx`=1 and `busy`=0 on the next edge.
  - The next FIFO byte is transmitted intact once `rst` drops.
  - Total pops equal bytes written.
- Enable drop mid-frame: deassert `enable` during START.
  - The current frame completes with `tx_done` pulsing.
  - No further `fifo_rd_en` while `enable`=0.
